popcount_sequencer: RTL and testbench
=====================================

// Module: popcount_sequencer
// PURPOSE
//   Streams a WIDTH-bit word through one shared 4-input ones-counter, one nibble per cycle.
//   Accumulates the nibble counts into a total population count.
//   Sits between a valid/ready producer and a valid/ready consumer.
//   Reuses one small combinational counter instead of a wide popcount tree.
// PARAMETERS
//   WIDTH  16               input word width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//   NIB    WIDTH/4          derived: number of nibbles, equal to the RUN cycles per word
//   CW     $clog2(WIDTH+1)  derived: width of the count result
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      producer has a word on in_data
//   in_ready   out  1      sequencer can accept a word (IDLE only)
//   in_data    in   WIDTH  word to be counted
//   out_valid  out  1      out_count holds a finished result
//   out_ready  in   1      consumer accepts the result
//   out_count  out  CW     number of 1 bits in the accepted word
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (rst=1 at a clk edge)
//     state=IDLE, shreg=0, acc=0, idx=0, out_valid=0, out_count=0, busy=0.
//     Reset has priority over every other event, including a reset mid-RUN or in DONE.
//     An in-flight word is discarded with no partial result.
//   FSM states: IDLE, RUN, DONE.
//   IDLE
//     in_ready=1.
//     On in_valid&&in_ready: shreg<=in_data, acc<=0, idx<=0, go to RUN.
//   RUN (in_ready=0)
//     Each edge: acc<=acc+ones(shreg[3:0]), shreg<=shreg>>4, idx<=idx+1.
//     When idx==NIB-1: the final add is done on that edge and the FSM goes to DONE.
//   DONE
//     out_valid=1; out_count=acc, stable until the handshake.
//     On out_valid&&out_ready: go to IDLE and drop out_valid on that edge.
//   Latency
//     Word accepted on edge T; out_valid is first high after edge T+NIB.
//     Throughput is at most one word per NIB+2 cycles.
//   Handshake
//     in_valid held high during RUN/DONE is ignored; the word is taken only on the next IDLE cycle.
//     There is no bypass, and there is no simultaneous accept while in DONE.
//     out_ready is ignored while out_valid=0.
//   Arithmetic
//     ones() returns 0..4 (3 bits), zero-extended to CW.
//     acc never exceeds WIDTH, so no overflow or saturation logic is needed.
//     idx is $clog2(NIB) bits, minimum 1, and wraps only through the IDLE reload.
//   Boundary cases
//     NIB=1 (WIDTH=4): RUN lasts exactly one edge.
//     all-zero word -> out_count=0; all-ones word -> out_count=WIDTH.
//     out_count keeps its value in IDLE after a handshake; it is rewritten only on the next DONE entry.
// STRUCTURE
//   Shared package popcount_pkg
//     typedef enum {IDLE, RUN, DONE} pc_state_t
//     localparam NIBBLE_W=4
//   Sub-module nibble_ones_count
//     Combinational, 4-bit in, 3-bit count out.
//     Built from the team's half-adder cells (two pairwise sums, then combine).
//   Top level: FSM, shreg, acc and idx registers, handshake logic.
// TESTING (WIDTH=16 unless noted)
//   1. Reset, then in_data=16'hFFFF with out_ready=1 -> out_valid after exactly 4 RUN edges.
//      Expect out_count=16, then IDLE with in_ready=1 on the next cycle.
//   2. in_data=16'h0000 -> out_count=0.
//      in_data=16'hA5A5 -> out_count=8.
//      in_data=16'h8001 -> out_count=2.
//   3. Backpressure: out_ready=0 for 5 cycles in DONE.
//      Expect out_count=11 (16'h7F1E) held stable, in_ready=0, and a new in_valid ignored.
//      Release out_ready -> one handshake, then IDLE.
//   4. Reset asserted in the 2nd RUN cycle -> next cycle all outputs are at reset values.
//      A following word 16'h00F0 -> out_count=4 with no leftover from the aborted word.
//   5. Back-to-back words with in_valid held high -> each accepted only in IDLE, at NIB+2-cycle spacing.
//   6. WIDTH=4 and WIDTH=32: random words checked against $countones.
//      Also check that out_valid rises exactly NIB edges after each accept.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the nibble-serial popcount sequencer.
// Holds the FSM state encoding and the half-adder cell used by the counter.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } pc_state_t;

    localparam int NIBBLE_W = 4;

    // Half-adder cell: returns {carry, sum}.
    function automatic logic [1:0] half_add(
        input logic a,
        input logic b
    );
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/nibble_ones_count.sv
// Combinational ones-counter for a single 4-bit nibble.
// Two pairwise half-adder sums are combined into a 0..4 result.
module nibble_ones_count
    import popcount_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [2:0]          count
);

    logic [1:0] pair_lo;
    logic [1:0] pair_hi;
    logic [1:0] sum_lsb;
    logic [1:0] sum_car;
    logic [1:0] sum_mid;

    // Pairwise sums of bits {1,0} and {3,2}, then a ripple combine.
    always_comb begin
        pair_lo = half_add(nibble[0], nibble[1]);
        pair_hi = half_add(nibble[2], nibble[3]);
        sum_lsb = half_add(pair_lo[0], pair_hi[0]);
        sum_car = half_add(pair_lo[1], pair_hi[1]);
        sum_mid = half_add(sum_car[0], sum_lsb[1]);
        count   = {sum_car[1] | sum_mid[1], sum_mid[0], sum_lsb[0]};
    end

endmodule

// File: rtl/popcount_sequencer.sv
// Nibble-serial population counter between two valid/ready ports.
// One shared 4-input counter is reused for NIB cycles per word.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIBBLE_W,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             busy
);

    localparam int            IW   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("popcount_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    pc_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [2:0]       nib_cnt;
    logic [CW-1:0]    acc_next;

    nibble_ones_count u_cnt (
        .nibble (shreg[NIBBLE_W-1:0]),
        .count  (nib_cnt)
    );

    // Running total including the nibble currently at the bottom of shreg.
    always_comb begin
        acc_next = acc + CW'(nib_cnt);
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    shreg <= shreg >> NIBBLE_W;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        out_count <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed and table-driven bench for popcount_sequencer.
// Exercises WIDTH=16 in depth plus WIDTH=4 and WIDTH=32 instances.
module tb_popcount_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv16, ir16, ov16, or16, b16;
    logic [15:0] id16;
    logic [4:0]  oc16;

    logic        iv4, ir4, ov4, or4, b4;
    logic [3:0]  id4;
    logic [2:0]  oc4;

    logic        iv32, ir32, ov32, or32, b32;
    logic [31:0] id32;
    logic [5:0]  oc32;

    popcount_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .out_valid(ov16), .out_ready(or16), .out_count(oc16),
        .busy(b16)
    );

    popcount_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_count(oc4),
        .busy(b4)
    );

    popcount_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .out_valid(ov32), .out_ready(or32), .out_count(oc32),
        .busy(b32)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;
        int          exp;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (ov16 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic send16(input logic [15:0] d, input int exp,
                          input string nm);
        int n;
        or16 = 1'b1;
        chk({nm, " in_ready"}, 64'(ir16), 1);
        iv16 = 1'b1;
        id16 = d;
        step();
        iv16 = 1'b0;
        chk({nm, " busy"}, 64'(b16), 1);
        wait16(n);
        chk({nm, " latency"}, 64'(n), 4);
        chk({nm, " count"}, 64'(oc16), 64'(exp));
        step();
        chk({nm, " valid drop"}, 64'(ov16), 0);
        chk({nm, " idle ready"}, 64'(ir16), 1);
        chk({nm, " held count"}, 64'(oc16), 64'(exp));
    endtask

    task automatic send4(input logic [3:0] d);
        int n;
        or4 = 1'b1;
        chk("w4 in_ready", 64'(ir4), 1);
        iv4 = 1'b1;
        id4 = d;
        step();
        iv4 = 1'b0;
        n = 0;
        while (ov4 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("w4 latency", 64'(n), 1);
        chk("w4 count", 64'(oc4), 64'($countones(d)));
        step();
        chk("w4 valid drop", 64'(ov4), 0);
    endtask

    task automatic send32(input logic [31:0] d);
        int n;
        or32 = 1'b1;
        chk("w32 in_ready", 64'(ir32), 1);
        iv32 = 1'b1;
        id32 = d;
        step();
        iv32 = 1'b0;
        n = 0;
        while (ov32 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("w32 latency", 64'(n), 8);
        chk("w32 count", 64'(oc32), 64'($countones(d)));
        step();
        chk("w32 valid drop", 64'(ov32), 0);
    endtask

    initial begin
        int          n;
        int          k;
        int          t;
        int          nres;
        logic        took;
        int          acc_t[3];
        logic [15:0] words[3];
        int          wexp[3];

        vecs[0] = '{16'hFFFF, 16};
        vecs[1] = '{16'h0000, 0};
        vecs[2] = '{16'hA5A5, 8};
        vecs[3] = '{16'h8001, 2};
        vecs[4] = '{16'h7F1E, 11};
        vecs[5] = '{16'h0F00, 4};

        rst  = 1'b1;
        iv16 = 1'b0; id16 = '0; or16 = 1'b0;
        iv4  = 1'b0; id4  = '0; or4  = 1'b0;
        iv32 = 1'b0; id32 = '0; or32 = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("reset in_ready", 64'(ir16), 1);
        chk("reset out_valid", 64'(ov16), 0);
        chk("reset out_count", 64'(oc16), 0);
        chk("reset busy", 64'(b16), 0);

        for (int i = 0; i < 6; i++) begin
            send16(vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure with a stray in_valid while DONE.
        or16 = 1'b0;
        iv16 = 1'b1;
        id16 = 16'h7F1E;
        step();
        iv16 = 1'b0;
        wait16(n);
        chk("bp latency", 64'(n), 4);
        iv16 = 1'b1;
        id16 = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 64'(ov16), 1);
            chk("bp count", 64'(oc16), 11);
            chk("bp in_ready", 64'(ir16), 0);
            step();
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        chk("bp still valid", 64'(ov16), 1);
        step();
        chk("bp release valid", 64'(ov16), 0);
        chk("bp release ready", 64'(ir16), 1);
        step();
        chk("bp stray ignored", 64'(b16), 0);

        // Reset in the second RUN cycle.
        iv16 = 1'b1;
        id16 = 16'hFFFF;
        step();
        iv16 = 1'b0;
        step();
        chk("abort busy pre", 64'(b16), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort out_valid", 64'(ov16), 0);
        chk("abort out_count", 64'(oc16), 0);
        chk("abort busy", 64'(b16), 0);
        chk("abort in_ready", 64'(ir16), 1);
        step();
        chk("abort no restart", 64'(b16), 0);
        send16(16'h00F0, 4, "post abort");

        // Back-to-back with in_valid held high.
        words[0] = 16'hFFFF; wexp[0] = 16;
        words[1] = 16'h0F0F; wexp[1] = 8;
        words[2] = 16'h1111; wexp[2] = 4;
        acc_t = '{0, 0, 0};
        or16 = 1'b1;
        iv16 = 1'b1;
        id16 = words[0];
        k    = 0;
        nres = 0;
        t    = 0;
        while (t < 80 && (k < 3 || nres < 3)) begin
            took = (ir16 === 1'b1) && iv16 && (k < 3);
            if (ov16 === 1'b1 && nres < 3) begin
                chk($sformatf("b2b count%0d", nres), 64'(oc16),
                    64'(wexp[nres]));
                nres++;
            end
            step();
            t++;
            if (took) begin
                acc_t[k] = t;
                k++;
                if (k < 3) id16 = words[k];
                else iv16 = 1'b0;
            end
        end
        iv16 = 1'b0;
        chk("b2b results", 64'(nres), 3);
        chk("b2b gap01", 64'(acc_t[1] - acc_t[0]), 6);
        chk("b2b gap12", 64'(acc_t[2] - acc_t[1]), 6);
        step();

        // WIDTH=4 and WIDTH=32 instances against $countones.
        send4(4'h0);
        send4(4'hF);
        for (int i = 0; i < 6; i++) begin
            send4(4'($urandom_range(0, 15)));
        end
        send32(32'h0);
        send32(32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            send32($urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
